// File: rtl/alu_seq_pkg.sv
// Shared encodings for alu_seq: opcodes, flag bit positions and FSM states.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_EOR  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ASL  = 4'h5;
  localparam logic [3:0] OP_LSR  = 4'h6;
  localparam logic [3:0] OP_ROL  = 4'h7;
  localparam logic [3:0] OP_ROR  = 4'h8;
  localparam logic [3:0] OP_INC  = 4'h9;
  localparam logic [3:0] OP_DEC  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_BIT  = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hD;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ADJ  = 1'b1;

endpackage

// File: rtl/alu_bcd_adjust.sv
// Packed-BCD correction of a binary sum/difference, one nibble at a time from the LSB,
// with the +6/-6 correction carry (or borrow) rippling into the next nibble.
module alu_bcd_adjust
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   sum,
  input  logic [WIDTH/4-1:0] half_carry,
  input  logic               sub,
  output logic [WIDTH-1:0]   res,
  output logic               carry
);

  localparam int NIB = WIDTH / 4;

  always_comb begin
    logic [4:0] t;
    logic       link;
    logic       dec;
    res   = '0;
    carry = 1'b0;
    link  = 1'b0;
    t     = '0;
    dec   = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (!sub) begin
        t   = {1'b0, sum[4*i +: 4]} + {4'b0000, link};
        dec = half_carry[i] | (t > 5'd9);
        if (dec) t = t + 5'd6;
      end else begin
        // No carry out of a nibble in a+~b+C means that digit borrowed.
        dec = half_carry[i];
        t   = {1'b0, sum[4*i +: 4]} - {4'b0000, link};
        if (!dec) t = t - 5'd6;
      end
      link = t[4];
      res[4*i +: 4] = t[3:0];
      carry = sub ? (dec & ~link) : dec;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent {N,V,Z,C} flags and an optional one-cycle BCD adjust step.
// Handshake: an op is accepted on a rising edge where op_valid && op_ready; op_ready is low in ADJ or while flags_ld is high.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DECIMAL_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dec_mode,
  input  logic             flags_ld,
  input  logic [3:0]       flags_in,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic [3:0]       flags
);

  localparam int NIB = (WIDTH / 4 > 0) ? WIDTH / 4 : 1;

  logic [0:0]       state;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   carry_vec;
  logic             carry_in;
  logic             ovf;
  logic             is_bcd;
  logic             res_wr;
  logic             nz_en;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] nxt_res;
  logic [3:0]       nxt_flags;
  logic [NIB-1:0]   hc;

  logic [WIDTH-1:0] bin_q;
  logic [NIB-1:0]   hc_q;
  logic             sub_q;
  logic [2:0]       nvz_q;
  logic [WIDTH-1:0] adj_res;
  logic             adj_c;

  assign op_ready = (state == ST_IDLE) && !flags_ld;
  assign is_bcd   = (DECIMAL_EN != 0) && dec_mode && (op == OP_ADD || op == OP_SUB);

  always_comb begin
    b_eff     = (op == OP_SUB || op == OP_CMP) ? ~b : b;
    carry_in  = (op == OP_CMP) ? 1'b1 : flags[FLAG_C];
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    ovf       = (a[WIDTH-1] ~^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    // Bit k of carry_vec is the carry into bit k, so nibble carries are every 4th bit.
    carry_vec = {1'b0, a} ^ {1'b0, b_eff} ^ sum;
    hc        = '0;
    for (int j = 0; j < NIB; j++) hc[j] = carry_vec[4*j+4];
  end

  always_comb begin
    val       = '0;
    res_wr    = 1'b0;
    nz_en     = 1'b1;
    nxt_res   = res;
    nxt_flags = flags;
    case (op)
      OP_ADD, OP_SUB: begin
        val = sum[WIDTH-1:0];
        res_wr = 1'b1;
        nxt_flags[FLAG_C] = sum[WIDTH];
        nxt_flags[FLAG_V] = ovf;
      end
      OP_CMP: begin
        val = sum[WIDTH-1:0];
        nxt_flags[FLAG_C] = sum[WIDTH];
      end
      OP_AND:  begin val = a & b; res_wr = 1'b1; end
      OP_EOR:  begin val = a ^ b; res_wr = 1'b1; end
      OP_OR:   begin val = a | b; res_wr = 1'b1; end
      OP_ASL: begin
        val = {a[WIDTH-2:0], 1'b0};
        res_wr = 1'b1;
        nxt_flags[FLAG_C] = a[WIDTH-1];
      end
      OP_LSR: begin
        val = {1'b0, a[WIDTH-1:1]};
        res_wr = 1'b1;
        nxt_flags[FLAG_C] = a[0];
      end
      OP_ROL: begin
        val = {a[WIDTH-2:0], flags[FLAG_C]};
        res_wr = 1'b1;
        nxt_flags[FLAG_C] = a[WIDTH-1];
      end
      OP_ROR: begin
        val = {flags[FLAG_C], a[WIDTH-1:1]};
        res_wr = 1'b1;
        nxt_flags[FLAG_C] = a[0];
      end
      OP_INC:  begin val = a + WIDTH'(1); res_wr = 1'b1; end
      OP_DEC:  begin val = a - WIDTH'(1); res_wr = 1'b1; end
      OP_PASS: begin val = b; res_wr = 1'b1; end
      OP_BIT: begin
        nz_en = 1'b0;
        nxt_flags[FLAG_Z] = ~|(a & b);
        nxt_flags[FLAG_N] = b[WIDTH-1];
        nxt_flags[FLAG_V] = b[WIDTH-2];
      end
      default: nz_en = 1'b0;
    endcase
    if (res_wr) nxt_res = val;
    if (nz_en) begin
      nxt_flags[FLAG_N] = val[WIDTH-1];
      nxt_flags[FLAG_Z] = ~|val;
    end
  end

  generate
    if (DECIMAL_EN != 0) begin : g_bcd
      alu_bcd_adjust #(.WIDTH(WIDTH)) u_bcd_adjust (
        .sum        (bin_q),
        .half_carry (hc_q),
        .sub        (sub_q),
        .res        (adj_res),
        .carry      (adj_c)
      );
    end else begin : g_no_bcd
      // ADJ is unreachable here; the stub just keeps the intermediate registers consumed.
      assign adj_res = bin_q;
      assign adj_c   = ^{hc_q, sub_q};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      res       <= '0;
      flags     <= '0;
      res_valid <= 1'b0;
      bin_q     <= '0;
      hc_q      <= '0;
      sub_q     <= 1'b0;
      nvz_q     <= '0;
    end else begin
      res_valid <= 1'b0;
      if (state == ST_ADJ) begin
        state     <= ST_IDLE;
        res       <= adj_res;
        res_valid <= 1'b1;
        flags     <= flags_ld ? flags_in : {nvz_q, adj_c};
      end else if (flags_ld) begin
        flags <= flags_in;
      end else if (op_valid) begin
        if (is_bcd) begin
          state <= ST_ADJ;
          bin_q <= sum[WIDTH-1:0];
          hc_q  <= hc;
          sub_q <= (op == OP_SUB);
          nvz_q <= {nxt_flags[FLAG_N], nxt_flags[FLAG_V], nxt_flags[FLAG_Z]};
        end else begin
          res_valid <= 1'b1;
          res       <= nxt_res;
          flags     <= nxt_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit decimal-enabled instance and a 16-bit binary-only instance.
module tb_alu_seq;
  import alu_seq_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v8, rdy8, dec8, fld8, rv8;
  logic [3:0] op8, fin8, fl8;
  logic [7:0] a8, b8, r8;

  logic        v16, rdy16, dec16, fld16, rv16;
  logic [3:0]  op16, fin16, fl16;
  logic [15:0] a16, b16, r16;

  alu_seq #(.WIDTH(8), .DECIMAL_EN(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .op_valid(v8), .op_ready(rdy8), .op(op8),
    .a(a8), .b(b8), .dec_mode(dec8), .flags_ld(fld8), .flags_in(fin8),
    .res(r8), .res_valid(rv8), .flags(fl8)
  );

  alu_seq #(.WIDTH(16), .DECIMAL_EN(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .op_valid(v16), .op_ready(rdy16), .op(op16),
    .a(a16), .b(b16), .dec_mode(dec16), .flags_ld(fld16), .flags_in(fin16),
    .res(r16), .res_valid(rv16), .flags(fl16)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every res_valid pulse on the 8-bit instance must match the next expected result
  always @(negedge clk) begin
    if (rst_n && rv8) begin
      if (exp_q.size() == 0) check("spurious_res_valid", 32'(rv8), 32'd0);
      else check("res_q", 32'(r8), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic issue(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic d, input logic [7:0] e);
    @(negedge clk);
    op8 = o; a8 = av; b8 = bv; dec8 = d; v8 = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    v8 = 1'b0; dec8 = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    @(negedge clk);
    v8 = 1'b0; fld8 = 1'b1; fin8 = f;
    @(negedge clk);
    fld8 = 1'b0;
  endtask

  // back-to-back table, starting from flags 0011 (C=1)
  logic [3:0] t_op [7] = '{OP_ROR, OP_ASL, OP_ROL, OP_LSR, OP_AND, OP_EOR, OP_OR};
  logic [7:0] t_a  [7] = '{8'h02, 8'h80, 8'h80, 8'h01, 8'hF0, 8'hFF, 8'h80};
  logic [7:0] t_b  [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hFF, 8'h01};
  logic [7:0] t_r  [7] = '{8'h81, 8'h00, 8'h01, 8'h00, 8'h30, 8'h00, 8'h81};
  logic [3:0] t_f  [7] = '{4'b1000, 4'b0011, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b1001};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    v8 = 0; dec8 = 0; fld8 = 0; fin8 = 0; op8 = 0; a8 = 0; b8 = 0;
    v16 = 0; dec16 = 0; fld16 = 0; fin16 = 0; op16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(negedge clk);
    check("rst_res", 32'(r8), 32'h00);
    check("rst_flags", 32'(fl8), 32'h0);
    check("rst_valid", 32'(rv8), 32'd0);
    check("rst_ready", 32'(rdy8), 32'd1);
    check("rst_res16", 32'(r16), 32'h0);
    check("rst_flags16", 32'(fl16), 32'h0);
    rst_n = 1'b1;

    // ADD with signed overflow
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80);
    idle();
    check("add_valid", 32'(rv8), 32'd1);
    check("add_flags", 32'(fl8), 32'b1100);
    @(negedge clk);
    check("add_valid_pulse", 32'(rv8), 32'd0);

    // flags_ld wins over op_valid
    @(negedge clk);
    fld8 = 1'b1; fin8 = 4'b0001; op8 = OP_PASS; b8 = 8'h55; v8 = 1'b1;
    #1 check("ld_blocks_ready", 32'(rdy8), 32'd0);
    @(negedge clk);
    fld8 = 1'b0; v8 = 1'b0;
    check("ld_flags", 32'(fl8), 32'b0001);
    check("ld_no_valid", 32'(rv8), 32'd0);
    check("ld_res_hold", 32'(r8), 32'h80);

    issue(OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF);
    idle();
    check("sub_flags", 32'(fl8), 32'b1000);
    issue(OP_CMP, 8'h40, 8'h40, 1'b0, 8'hFF);
    idle();
    check("cmp_flags", 32'(fl8), 32'b0011);
    check("cmp_res_hold", 32'(r8), 32'hFF);

    // shifts/rotates/logic back-to-back: each issue edge shows the previous result
    for (int i = 0; i < 7; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b0, t_r[i]);
      if (i > 0) begin
        check("b2b_valid", 32'(rv8), 32'd1);
        check("b2b_flags", 32'(fl8), 32'(t_f[i-1]));
      end
    end
    idle();
    check("b2b_last_valid", 32'(rv8), 32'd1);
    check("b2b_last_flags", 32'(fl8), 32'(t_f[6]));

    // BCD ADD 58+46
    load_flags(4'b0000);
    issue(OP_ADD, 8'h58, 8'h46, 1'b1, 8'h04);
    idle();
    check("bcd_add_adj_ready", 32'(rdy8), 32'd0);
    check("bcd_add_no_early", 32'(rv8), 32'd0);
    @(negedge clk);
    check("bcd_add_valid", 32'(rv8), 32'd1);
    check("bcd_add_ready", 32'(rdy8), 32'd1);
    check("bcd_add_flags", 32'(fl8), 32'b1101);

    // BCD SUB 12-21
    load_flags(4'b0001);
    issue(OP_SUB, 8'h12, 8'h21, 1'b1, 8'h91);
    idle();
    check("bcd_sub_adj_ready", 32'(rdy8), 32'd0);
    @(negedge clk);
    check("bcd_sub_valid", 32'(rv8), 32'd1);
    check("bcd_sub_flags", 32'(fl8), 32'b1000);

    load_flags(4'b0001);
    issue(OP_BIT, 8'h01, 8'hC0, 1'b0, 8'h91);
    idle();
    check("bit_flags", 32'(fl8), 32'b1111);
    issue(OP_INC, 8'hFF, 8'h00, 1'b0, 8'h00);
    idle();
    check("inc_flags", 32'(fl8), 32'b0111);
    issue(OP_DEC, 8'h00, 8'h00, 1'b0, 8'hFF);
    idle();
    check("dec_flags", 32'(fl8), 32'b1101);
    issue(OP_PASS, 8'h00, 8'h5A, 1'b0, 8'h5A);
    idle();
    check("pass_flags", 32'(fl8), 32'b0101);
    issue(4'hF, 8'h12, 8'h34, 1'b0, 8'h5A);
    idle();
    check("unused_valid", 32'(rv8), 32'd1);
    check("unused_flags", 32'(fl8), 32'b0101);

    // reset during ADJ
    load_flags(4'b1010);
    @(negedge clk);
    op8 = OP_ADD; a8 = 8'h58; b8 = 8'h46; dec8 = 1'b1; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0; dec8 = 1'b0;
    check("adj_before_rst", 32'(rdy8), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res", 32'(r8), 32'h00);
    check("mid_rst_flags", 32'(fl8), 32'h0);
    check("mid_rst_valid", 32'(rv8), 32'd0);
    check("mid_rst_ready", 32'(rdy8), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(rv8), 32'd0);
    end
    issue(OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02);
    idle();
    check("post_rst_add_flags", 32'(fl8), 32'b0000);

    // 16-bit binary-only instance: dec_mode has no effect, latency stays 1
    @(negedge clk);
    op16 = OP_ADD; a16 = 16'hFFFF; b16 = 16'h0001; dec16 = 1'b1; v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0; dec16 = 1'b0;
    check("w16_valid", 32'(rv16), 32'd1);
    check("w16_res", 32'(r16), 32'h0000);
    check("w16_flags", 32'(fl16), 32'b0011);
    check("w16_ready", 32'(rdy16), 32'd1);

    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
